// File: rtl/iic_pkg.sv
// Shared IIC definitions: target FSM state codes and bus bit meanings.
package iic_pkg;

   typedef logic [3:0] iic_state_t;

   localparam iic_state_t StIdle    = 4'd0;
   localparam iic_state_t StDevAddr = 4'd1;
   localparam iic_state_t StAddrAck = 4'd2;
   localparam iic_state_t StRegAddr = 4'd3;
   localparam iic_state_t StRegAck  = 4'd4;
   localparam iic_state_t StWrData  = 4'd5;
   localparam iic_state_t StWrAck   = 4'd6;
   localparam iic_state_t StRdData  = 4'd7;
   localparam iic_state_t StRdAck   = 4'd8;
   localparam iic_state_t StIgnore  = 4'd9;

   // R/W bit of the address byte.
   localparam logic IIC_RW_WRITE = 1'b0;
   localparam logic IIC_RW_READ  = 1'b1;

   // Level on SDA during the acknowledge slot.
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

// File: rtl/iic_slave_regs_if.sv
// IIC pin bundle. IICSDAIn is the resolved (wired-AND) SDA level seen at the pad.
interface iic_slave_regs_if;

   logic IICSCL;
   logic IICSDAIn;
   logic IICSDAOe;

   modport master (output IICSCL, output IICSDAIn, input IICSDAOe);
   modport slave  (input IICSCL, input IICSDAIn, output IICSDAOe);

endinterface

// File: rtl/iic_line_sync.sv
// Synchronises SCL/SDA into sys_clk and flags SCL edges plus START/STOP conditions.
module iic_line_sync (
   input  logic sys_clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o,
   output logic sda_s_o
);

   logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_hist_q, scl_hist_d;
   logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_hist_q, sda_hist_d;

   // Two sync stages followed by one history stage per line.
   always_comb begin
      scl_meta_d = scl_i;
      scl_sync_d = scl_meta_q;
      scl_hist_d = scl_sync_q;
      sda_meta_d = sda_i;
      sda_sync_d = sda_meta_q;
      sda_hist_d = sda_sync_q;
   end

   // Reset to the idle-bus level so leaving reset creates no false START/STOP.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_hist_q <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_meta_q <= scl_meta_d;
         scl_sync_q <= scl_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_meta_q <= sda_meta_d;
         sda_sync_q <= sda_sync_d;
         sda_hist_q <= sda_hist_d;
      end
   end

   // Edge and bus-condition flags; START/STOP need SCL high in both compared samples.
   always_comb begin
      scl_rise_o  = scl_sync_q & ~scl_hist_q;
      scl_fall_o  = ~scl_sync_q & scl_hist_q;
      start_det_o = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
      stop_det_o  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
      sda_s_o     = sda_sync_q;
   end

endmodule

// File: rtl/iic_slave_regs.sv
// IIC target with an auto-incrementing byte register file and a local write port.
module iic_slave_regs
   import iic_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
   parameter int unsigned REG_DEPTH  = 16,
   parameter int unsigned PTR_W      = 4
) (
   input  logic             sys_clk,
   input  logic             rst,
   iic_slave_regs_if.slave  bus,
   output logic             busy,
   output logic             wr_valid,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   input  logic             ext_we,
   input  logic [PTR_W-1:0] ext_addr,
   input  logic [7:0]       ext_data
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   iic_line_sync u_sync (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .scl_i       (bus.IICSCL),
      .sda_i       (bus.IICSDAIn),
      .scl_rise_o  (scl_rise),
      .scl_fall_o  (scl_fall),
      .start_det_o (start_det),
      .stop_det_o  (stop_det),
      .sda_s_o     (sda_s)
   );

   iic_state_t       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [7:0]       sh_q, sh_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             oe_q, oe_d, busy_q, busy_d;
   logic             wr_valid_q, wr_valid_d;
   logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic [7:0]       regs_q [REG_DEPTH];
   logic [7:0]       regs_d [REG_DEPTH];

   logic [7:0] byte_in;
   logic       rx_state, rx_bit, rx_last, rx_done, mst_we;

   // Receive bookkeeping: cnt counts sampled bits; 8 means "byte held, ACK on next fall".
   always_comb begin
      byte_in  = {sh_q[6:0], sda_s};
      rx_state = (state_q == StDevAddr) || (state_q == StRegAddr) || (state_q == StWrData);
      rx_bit   = rx_state && scl_rise && (cnt_q < 4'd8);
      rx_last  = rx_bit && (cnt_q == 4'd7);
      rx_done  = rx_state && scl_fall && (cnt_q == 4'd8);
   end

   // Protocol FSM; START and STOP override every state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      mst_we     = 1'b0;
      if (start_det) begin
         state_d = StDevAddr;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = StIdle;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         if (rx_bit) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
         end
         case (state_q)
            StDevAddr: begin
               if (rx_done) begin
                  cnt_d = 4'd0;
                  if (sh_q[7:1] == SLAVE_ADDR) begin
                     oe_d    = 1'b1;
                     busy_d  = 1'b1;
                     state_d = StAddrAck;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = StIgnore;
                  end
               end
            end
            StRegAddr: begin
               if (rx_last) ptr_d = byte_in[PTR_W-1:0];
               if (rx_done) begin
                  cnt_d   = 4'd0;
                  oe_d    = 1'b1;
                  state_d = StRegAck;
               end
            end
            StWrData: begin
               if (rx_last) begin
                  mst_we     = 1'b1;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = byte_in;
                  ptr_d      = ptr_q + PTR_W'(1);
               end
               if (rx_done) begin
                  cnt_d   = 4'd0;
                  oe_d    = 1'b1;
                  state_d = StWrAck;
               end
            end
            StRegAck, StWrAck: begin
               if (scl_fall) begin
                  oe_d    = 1'b0;
                  cnt_d   = 4'd0;
                  state_d = StWrData;
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  cnt_d = 4'd0;
                  unique case (sh_q[0])
                     IIC_RW_WRITE: begin
                        oe_d    = 1'b0;
                        state_d = StRegAddr;
                     end
                     IIC_RW_READ: begin
                        sh_d    = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                        state_d = StRdData;
                     end
                  endcase
               end
            end
            StRdData: begin
               if (scl_fall) begin
                  if (cnt_q == 4'd7) begin
                     oe_d    = 1'b0;
                     cnt_d   = 4'd0;
                     state_d = StRdAck;
                  end else begin
                     sh_d  = {sh_q[6:0], 1'b0};
                     oe_d  = ~sh_q[6];
                     cnt_d = cnt_q + 4'd1;
                  end
               end
            end
            StRdAck: begin
               // cnt=1 marks "master ACKed, reload on the coming fall".
               if (scl_rise && (cnt_q == 4'd0)) begin
                  ptr_d = ptr_q + PTR_W'(1);
                  unique case (sda_s)
                     ACK:  cnt_d = 4'd1;
                     NACK: state_d = StIgnore;
                  endcase
               end else if (scl_fall && (cnt_q == 4'd1)) begin
                  sh_d    = regs_q[ptr_q];
                  oe_d    = ~regs_q[ptr_q][7];
                  cnt_d   = 4'd0;
                  state_d = StRdData;
               end
            end
            default: ;
         endcase
      end
   end

   // Register file: master write is applied last so it wins an index clash.
   always_comb begin
      regs_d = regs_q;
      if (ext_we) regs_d[ext_addr] = ext_data;
      if (mst_we) regs_d[ptr_q] = byte_in;
   end

   // State and register file update.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         sh_q       <= 8'd0;
         ptr_q      <= '0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'd0;
         regs_q     <= '{default: 8'd0};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         ptr_q      <= ptr_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         regs_q     <= regs_d;
      end
   end

   // Outputs come straight from flops.
   always_comb begin
      bus.IICSDAOe = oe_q;
      busy         = busy_q;
      wr_valid     = wr_valid_q;
      wr_addr      = wr_addr_q;
      wr_data      = wr_data_q;
   end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bit-banged IIC master driving iic_slave_regs, checked against a register-file model.
module tb_iic_slave_regs;
   import iic_pkg::*;

   localparam int Q = 6;   // sys_clk cycles per quarter SCL period

   logic       sys_clk = 1'b0;
   logic       rst;
   logic       busy, wr_valid, ext_we;
   logic [3:0] wr_addr, ext_addr;
   logic [7:0] wr_data, ext_data;
   logic       m_scl, m_sda, sda_line;

   always #5 sys_clk = ~sys_clk;

   iic_slave_regs_if bus ();
   assign sda_line     = m_sda & ~bus.IICSDAOe;
   assign bus.IICSCL   = m_scl;
   assign bus.IICSDAIn = sda_line;

   iic_slave_regs #(.SLAVE_ADDR(7'h3C), .REG_DEPTH(16), .PTR_W(4)) dut (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .ext_we   (ext_we),
      .ext_addr (ext_addr),
      .ext_data (ext_data)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: register contents, pointer, expected write notifications.
   logic [7:0]  mregs [16];
   logic [3:0]  mptr;
   logic [11:0] expq [$];
   logic [11:0] wrq [$];
   logic [7:0]  txd [$];
   bit          oe_seen, busy_seen;

   always @(negedge sys_clk) begin
      if (wr_valid === 1'b1) wrq.push_back({wr_addr, wr_data});
      if (bus.IICSDAOe === 1'b1) oe_seen = 1'b1;
      if (busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge sys_clk);
   endtask

   task automatic send_bit(input logic b, input bit ext_pulse);
      wait_q();
      m_sda = b;
      wait_q();
      m_scl = 1'b1;
      // Slave commits the sampled bit 3 sys_clk edges after SCL rises.
      for (int i = 0; i < 2 * Q; i++) begin
         @(negedge sys_clk);
         ext_we = ext_pulse && (i == 1);
      end
      m_scl = 1'b0;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      wait_q();
      m_scl = 1'b1;
      wait_q();
      m_sda = 1'b0;
      wait_q();
      m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      wait_q();
      m_scl = 1'b1;
      wait_q();
      m_sda = 1'b1;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, input bit ext_last, output bit acked);
      for (int i = 7; i >= 0; i--) send_bit(d[i], ext_last && (i == 0));
      wait_q();
      m_sda = 1'b1;
      wait_q();
      m_scl = 1'b1;
      wait_q();
      acked = (sda_line == 1'b0);
      wait_q();
      m_scl = 1'b0;
   endtask

   task automatic read_byte(input bit nack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         wait_q();
         m_sda = 1'b1;
         wait_q();
         m_scl = 1'b1;
         wait_q();
         d[i] = sda_line;
         wait_q();
         m_scl = 1'b0;
      end
      send_bit(nack, 1'b0);
   endtask

   task automatic ext_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge sys_clk);
      ext_we = 1'b1; ext_addr = a; ext_data = d;
      @(negedge sys_clk);
      ext_we = 1'b0;
      mregs[a] = d;
   endtask

   // Writes txd starting at ptr; clash_idx selects a byte whose commit cycle gets a
   // simultaneous local write (ext_addr/ext_data preset by caller).
   task automatic xfer_write(input logic [7:0] ptr, input int clash_idx, input string tag);
      bit ack;
      wrq.delete();
      expq.delete();
      i2c_start();
      write_byte({7'h3C, IIC_RW_WRITE}, 1'b0, ack);
      check({tag, "_addr_ack"}, 32'(ack), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      write_byte(ptr, 1'b0, ack);
      check({tag, "_ptr_ack"}, 32'(ack), 32'd1);
      mptr = ptr[3:0];
      foreach (txd[i]) begin
         write_byte(txd[i], i == clash_idx, ack);
         check($sformatf("%s_data%0d_ack", tag, i), 32'(ack), 32'd1);
         mregs[mptr] = txd[i];
         expq.push_back({mptr, txd[i]});
         mptr = mptr + 4'd1;
      end
      i2c_stop();
      check({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
      check({tag, "_wr_count"}, 32'(wrq.size()), 32'(expq.size()));
      foreach (expq[i])
         if (i < wrq.size())
            check($sformatf("%s_wr%0d", tag, i), 32'(wrq[i]), 32'(expq[i]));
   endtask

   task automatic xfer_read(input bit set_ptr, input logic [7:0] ptr, input int n,
                            input string tag);
      bit ack;
      logic [7:0] d;
      if (set_ptr) begin
         i2c_start();
         write_byte({7'h3C, IIC_RW_WRITE}, 1'b0, ack);
         write_byte(ptr, 1'b0, ack);
         check({tag, "_ptr_ack"}, 32'(ack), 32'd1);
         mptr = ptr[3:0];
      end
      i2c_start();
      write_byte({7'h3C, IIC_RW_READ}, 1'b0, ack);
      check({tag, "_raddr_ack"}, 32'(ack), 32'd1);
      for (int i = 0; i < n; i++) begin
         read_byte(i == n - 1, d);
         check($sformatf("%s_rd%0d", tag, i), 32'(d), 32'(mregs[mptr]));
         mptr = mptr + 4'd1;
      end
      check({tag, "_released_after_nack"}, 32'(bus.IICSDAOe), 32'd0);
      i2c_stop();
   endtask

   initial begin
      bit ack;
      logic [7:0] p;
      int n;
      m_scl = 1'b1; m_sda = 1'b1;
      ext_we = 1'b0; ext_addr = 4'd0; ext_data = 8'd0;
      oe_seen = 1'b0; busy_seen = 1'b0;
      foreach (mregs[i]) mregs[i] = 8'd0;
      mptr = 4'd0;
      rst = 1'b1;
      repeat (5) @(negedge sys_clk);
      check("rst_oe", 32'(bus.IICSDAOe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge sys_clk);

      // Basic write, then read back with repeated START; reg 7 proves the pointer ends at 7.
      txd = '{8'hA5, 8'h5A};
      xfer_write(8'h05, -1, "wr_basic");
      ext_write(4'd7, 8'h77);
      ext_write(4'd3, 8'hC3);
      xfer_read(1'b1, 8'h05, 2, "rd_basic");
      xfer_read(1'b0, 8'h00, 1, "rd_cur_ptr");
      xfer_read(1'b1, 8'h03, 1, "rd_ext");

      // Foreign address: never acknowledged, never busy, nothing written.
      oe_seen = 1'b0; busy_seen = 1'b0; wrq.delete();
      i2c_start();
      write_byte({7'h3D, IIC_RW_WRITE}, 1'b0, ack);
      check("other_addr_nack", 32'(ack), 32'd0);
      write_byte(8'h05, 1'b0, ack);
      write_byte(8'h99, 1'b0, ack);
      i2c_stop();
      check("other_oe_never", 32'(oe_seen), 32'd0);
      check("other_busy_never", 32'(busy_seen), 32'd0);
      check("other_no_writes", 32'(wrq.size()), 32'd0);
      xfer_read(1'b1, 8'h05, 1, "other_unchanged");

      // Pointer wrap with a local write to the same index in the master's commit cycle.
      ext_addr = 4'd0; ext_data = 8'hEE;
      txd = '{8'h11, 8'h22};
      xfer_write(8'h0F, 1, "wrap");
      xfer_read(1'b1, 8'h0F, 2, "wrap_rb");

      // STOP after 4 data bits discards the partial byte.
      wrq.delete();
      i2c_start();
      write_byte({7'h3C, IIC_RW_WRITE}, 1'b0, ack);
      write_byte(8'h09, 1'b0, ack);
      mptr = 4'd9;
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      i2c_stop();
      check("partial_no_write", 32'(wrq.size()), 32'd0);
      check("partial_oe", 32'(bus.IICSDAOe), 32'd0);
      check("partial_busy", 32'(busy), 32'd0);
      txd = '{8'($urandom)};
      xfer_write(8'h09, -1, "after_partial");
      xfer_read(1'b1, 8'h09, 1, "after_partial_rb");

      // Random bursts; upper pointer bits are random and must be ignored.
      for (int k = 0; k < 4; k++) begin
         p = 8'($urandom);
         n = 1 + int'($urandom_range(2));
         txd.delete();
         for (int i = 0; i < n; i++) txd.push_back(8'($urandom));
         xfer_write(p, -1, $sformatf("rnd%0d", k));
         xfer_read(1'b1, p, n, $sformatf("rnd%0d_rb", k));
      end

      // Reset while the ACK is being driven.
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : 1'(8'h78 >> i), 1'b0);
      wait_q();
      wait_q();
      check("ack_before_rst", 32'(bus.IICSDAOe), 32'd1);
      rst = 1'b1;
      @(negedge sys_clk);
      check("oe_after_rst", 32'(bus.IICSDAOe), 32'd0);
      @(negedge sys_clk);
      rst = 1'b0;
      foreach (mregs[i]) mregs[i] = 8'd0;
      mptr = 4'd0;
      i2c_stop();
      xfer_read(1'b0, 8'h00, 1, "post_rst_reg0");
      xfer_read(1'b1, 8'h05, 2, "post_rst_reg5");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
